// File: rtl/avg_pooling_layer.sv
// 2x2 average pooling over a row-major signed image; build with AVG_POOL_ROUND_EN for round-half-up, else floor.
// Latency: one pooled element per enabled cycle; finished_pool rises on the 197th edge counting the start edge (defaults).
// Backpressure: enable low pauses the run in place; in DONE, enable low returns to IDLE keeping pool contents.
module avg_pooling_layer #(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter int IN_W  = 8,
    parameter int OUT_W = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic signed [IN_W-1:0]  img  [0:IMG_W*IMG_H-1],
    output logic                    finished_pool,
    output logic signed [OUT_W-1:0] pool [0:(IMG_W/2)*(IMG_H/2)-1]
);

    localparam int PW   = IMG_W / 2;
    localparam int NOUT = PW * (IMG_H / 2);
    localparam int NPIX = IMG_W * IMG_H;
    localparam int IDXW = (NOUT > 1) ? $clog2(NOUT) : 1;
    localparam int CW   = (PW > 1) ? $clog2(PW) : 1;
    localparam int AW   = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int SW   = IN_W + 2;

    typedef enum logic [1:0] {IDLE, POOL, DONE} state_t;

    state_t          state_q;
    state_t          state_d;
    logic            wr;
    logic            last;
    logic [IDXW-1:0] idx;
    logic [CW-1:0]   col;
    // base is the flat index of the top-left pixel of the current 2x2 block
    logic [AW-1:0]   base;

    logic signed [SW-1:0]    p00, p01, p10, p11, sum, avg;
    logic signed [OUT_W-1:0] elem;

    assign last = (idx == IDXW'(NOUT - 1));

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic and the per-cycle write strobe
    always_comb begin
        state_d = state_q;
        wr      = 1'b0;
        case (state_q)
            IDLE: if (enable) state_d = POOL;
            POOL: if (enable) begin
                wr = 1'b1;
                if (last) state_d = DONE;
            end
            DONE: if (!enable) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Gather the current 2x2 block and average it; the sum is two bits wider so it cannot overflow
    always_comb begin
        p00 = SW'(img[base]);
        p01 = SW'(img[base + AW'(1)]);
        p10 = SW'(img[base + AW'(IMG_W)]);
        p11 = SW'(img[base + AW'(IMG_W + 1)]);
        sum = p00 + p01 + p10 + p11;
`ifdef AVG_POOL_ROUND_EN
        avg = (sum + SW'(2)) >>> 2;
`else
        avg = sum >>> 2;
`endif
        elem = OUT_W'(avg);
    end

    // Element write, block walk, and completion flag
    always_ff @(posedge clk) begin
        if (reset) begin
            idx           <= '0;
            col           <= '0;
            base          <= '0;
            finished_pool <= 1'b0;
            for (int k = 0; k < NOUT; k++) pool[k] <= '0;
        end else begin
            if (wr) begin
                pool[idx] <= elem;
                if (last) begin
                    idx           <= '0;
                    col           <= '0;
                    base          <= '0;
                    finished_pool <= 1'b1;
                end else begin
                    idx <= idx + IDXW'(1);
                    if (col == CW'(PW - 1)) begin
                        // end of a pooled row: skip the odd image row as well
                        col  <= '0;
                        base <= base + AW'(IMG_W + 2);
                    end else begin
                        col  <= col + CW'(1);
                        base <= base + AW'(2);
                    end
                end
            end
            if (state_q == DONE && !enable) finished_pool <= 1'b0;
        end
    end

endmodule

// File: tb/tb_avg_pooling_layer.sv
// Bench for avg_pooling_layer: randomized and directed images against an arithmetic reference model.
// Latency: expected finish cycle is queued with each run and checked by the monitor on finished_pool rise.
// Backpressure: mid-run enable pauses, DONE exit/re-entry and mid-run reset are exercised.
module tb_avg_pooling_layer;

    localparam int IMG_W = 28;
    localparam int IMG_H = 28;
    localparam int IN_W  = 8;
    localparam int OUT_W = 16;
    localparam int PW    = IMG_W / 2;
    localparam int PH    = IMG_H / 2;
    localparam int NOUT  = PW * PH;
    localparam int NPIX  = IMG_W * IMG_H;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    enable;
    logic signed [IN_W-1:0]  img  [0:NPIX-1];
    logic                    finished_pool;
    logic signed [OUT_W-1:0] pool [0:NOUT-1];

    avg_pooling_layer #(.IMG_W(IMG_W), .IMG_H(IMG_H), .IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .clk(clk), .reset(reset), .enable(enable), .img(img),
        .finished_pool(finished_pool), .pool(pool)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    int exp_q[$];
    int fin_q[$];
    int pix[NPIX];
    int exp_cur[NOUT];
    int last_exp[NOUT];

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference: average of four pixels, either floor or round-half-up
    function automatic int avg4(input int s);
        int t;
        t = s;
`ifdef AVG_POOL_ROUND_EN
        t = t + 2;
`endif
        if (t >= 0) return t / 4;
        else        return -((-t + 3) / 4);
    endfunction

    function automatic void model();
        for (int r = 0; r < PH; r++)
            for (int c = 0; c < PW; c++)
                exp_cur[r*PW + c] = avg4(pix[2*r*IMG_W + 2*c] + pix[2*r*IMG_W + 2*c + 1]
                                       + pix[(2*r+1)*IMG_W + 2*c] + pix[(2*r+1)*IMG_W + 2*c + 1]);
    endfunction

    task automatic fill_random();
        for (int k = 0; k < NPIX; k++) pix[k] = int'($urandom_range(255)) - 128;
    endtask

    task automatic fill_const(input int v);
        for (int k = 0; k < NPIX; k++) pix[k] = v;
    endtask

    // Drive image, queue expectation, raise enable (called at a negedge)
    task automatic start_run(input int pause_len);
        for (int k = 0; k < NPIX; k++) img[k] = 8'(pix[k]);
        model();
        for (int k = 0; k < NOUT; k++) exp_q.push_back(exp_cur[k]);
        fin_q.push_back(cyc + 197 + pause_len);
        enable = 1'b1;
    endtask

    task automatic run(input int pause_at, input int pause_len);
        int t;
        start_run(pause_len);
        if (pause_len > 0) begin
            repeat (pause_at) @(negedge clk);
            enable = 1'b0;
            chk("stale_tail", int'(pool[NOUT-1]), last_exp[NOUT-1]);
            chk("early_head", int'(pool[0]), exp_cur[0]);
            repeat (pause_len) @(negedge clk);
            enable = 1'b1;
        end
        t = 0;
        while (finished_pool !== 1'b1 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (finished_pool !== 1'b1) chk("finish_timeout", 0, 1);
        repeat (2) @(negedge clk);
        chk("done_hold", int'(finished_pool), 1);
        chk("done_hold_pool", int'(pool[NOUT-1]), exp_cur[NOUT-1]);
        enable = 1'b0;
        @(negedge clk);
        chk("done_exit", int'(finished_pool), 0);
        chk("keep_pool", int'(pool[NOUT-1]), exp_cur[NOUT-1]);
        last_exp = exp_cur;
    endtask

    task automatic chk_cleared(input string name);
        int nz;
        nz = 0;
        for (int k = 0; k < NOUT; k++) if (pool[k] !== '0) nz++;
        chk(name, nz, 0);
        chk("finished_cleared", int'(finished_pool), 0);
    endtask

    // Monitor: on each finished_pool rise pop and compare the queued expectation
    logic fin_prev = 1'b0;
    always @(negedge clk) begin
        if (finished_pool === 1'b1 && !fin_prev) begin
            if (fin_q.size() == 0) begin
                chk("unexpected_finish", 1, 0);
            end else begin
                chk("finish_cycle", cyc, fin_q.pop_front());
                for (int k = 0; k < NOUT; k++) chk("pool_elem", int'(pool[k]), exp_q.pop_front());
            end
        end
        fin_prev = (finished_pool === 1'b1);
    end

    initial begin
        reset  = 1'b1;
        enable = 1'b0;
        for (int k = 0; k < NPIX; k++) img[k] = '0;
        repeat (3) @(negedge clk);
        chk_cleared("reset_pool");
        reset = 1'b0;
        for (int k = 0; k < NOUT; k++) last_exp[k] = 0;

        // Single nonzero pixel in block (0,0)
        fill_const(0); pix[0] = 8;
        run(0, 0);
        // Extremes
        fill_const(-128); run(0, 0);
        fill_const(127);  run(0, 0);
        // Rounding boundary cases in block (0,0)
        fill_random(); pix[0] = 2;  pix[1] = 0; pix[IMG_W] = 0; pix[IMG_W+1] = 0;
        run(0, 0);
        fill_random(); pix[0] = -1; pix[1] = 0; pix[IMG_W] = 0; pix[IMG_W+1] = 0;
        run(0, 0);
        // Ramp with a 10-cycle pause mid-run
        for (int k = 0; k < NPIX; k++) pix[k] = (k % 100) - 50;
        run(60, 10);
        // Random images, back to back through DONE -> IDLE -> POOL
        fill_random(); run(100, 3);
        fill_random(); run(0, 0);

        // Reset 50 cycles into a run aborts it
        fill_random();
        start_run(0);
        repeat (50) @(negedge clk);
        reset  = 1'b1;
        enable = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        chk_cleared("midrun_reset_pool");
        void'(fin_q.pop_back());
        repeat (NOUT) void'(exp_q.pop_back());
        for (int k = 0; k < NOUT; k++) last_exp[k] = 0;
        @(negedge clk);
        chk("idle_after_reset", int'(finished_pool), 0);
        fill_random(); run(0, 0);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", fin_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
